// File: rtl/accel_mem_pkg.sv
// Shared sizes and register-space offsets for the accelerator memory responder.
package accel_mem_pkg;

    localparam int DATA_W = 32;
    localparam int MEM_AW = 10;

    localparam logic [1:0] CTRL_OFS   = 2'd0;
    localparam logic [1:0] STATUS_OFS = 2'd1;
    localparam logic [1:0] CYCLES_OFS = 2'd2;

    localparam int ERR_CLR_BIT = 2;

endpackage

// File: rtl/sp_ram.sv
// Single-port synchronous RAM; read data appears one cycle after an enabled access.
module sp_ram #(
    parameter int DATA_W = 32,
    parameter int AW     = 10
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**AW];

    // Read-before-write: a write cycle returns the old contents.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/accel_mem_resp.sv
// Shared data memory plus MCU register space for an accelerator; ext_sel chooses
// which requester owns the single RAM port.
module accel_mem_resp
    import accel_mem_pkg::*;
#(
    parameter int DATA_W = accel_mem_pkg::DATA_W,
    parameter int MEM_AW = accel_mem_pkg::MEM_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mcu_req,
    input  logic              mcu_we,
    input  logic [MEM_AW:0]   mcu_addr,
    input  logic [DATA_W-1:0] mcu_wdata,
    output logic              mcu_gnt,
    output logic [DATA_W-1:0] mcu_rdata,
    output logic              mcu_rvalid,
    input  logic              acc_req,
    input  logic              acc_we,
    input  logic [MEM_AW-1:0] acc_addr,
    input  logic [DATA_W-1:0] acc_wdata,
    output logic [DATA_W-1:0] acc_rdata,
    input  logic              ext_sel,
    input  logic              done,
    input  logic              done_e,
    input  logic              running,
    input  logic              running_e,
    output logic              start
);

    logic              mcu_mem_acc;
    logic              mcu_reg_acc;
    logic              acc_acc;
    logic              ram_en;
    logic              ram_we;
    logic [MEM_AW-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    logic              start_q;
    logic              done_q;
    logic              running_q;
    logic              err_q;
    logic [DATA_W-1:0] cycles_q;
    logic              ctrl_start_wr;
    logic              err_clr_wr;
    logic              err_set;
    logic [DATA_W-1:0] reg_rd_val;

    logic              mcu_mem_pend;
    logic              mcu_reg_pend;
    logic [DATA_W-1:0] reg_rdata_q;
    logic [DATA_W-1:0] mcu_hold_q;
    logic              acc_pend;
    logic [DATA_W-1:0] acc_hold_q;

    assign mcu_reg_acc = mcu_req && mcu_addr[MEM_AW];
    assign mcu_mem_acc = mcu_req && !mcu_addr[MEM_AW] && ext_sel;
    assign acc_acc     = acc_req && !ext_sel;
    assign err_set     = acc_req && ext_sel;
    assign mcu_gnt     = mcu_reg_acc || mcu_mem_acc;

    assign ctrl_start_wr = mcu_reg_acc && mcu_we && (mcu_addr[1:0] == CTRL_OFS)
                           && mcu_wdata[0] && !running_q;
    assign err_clr_wr    = mcu_reg_acc && mcu_we && (mcu_addr[1:0] == STATUS_OFS)
                           && mcu_wdata[ERR_CLR_BIT];

    always_comb begin
        ram_en    = acc_acc;
        ram_we    = acc_we;
        ram_addr  = acc_addr;
        ram_wdata = acc_wdata;
        if (ext_sel) begin
            ram_en    = mcu_mem_acc;
            ram_we    = mcu_we;
            ram_addr  = mcu_addr[MEM_AW-1:0];
            ram_wdata = mcu_wdata;
        end
    end

    always_comb begin
        reg_rd_val = '0;
        case (mcu_addr[1:0])
            STATUS_OFS: reg_rd_val = {{(DATA_W-3){1'b0}}, err_q, running_q, done_q};
            CYCLES_OFS: reg_rd_val = cycles_q;
            default:    reg_rd_val = '0;
        endcase
    end

    sp_ram #(
        .DATA_W (DATA_W),
        .AW     (MEM_AW)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q   <= 1'b0;
            done_q    <= 1'b0;
            running_q <= 1'b0;
            err_q     <= 1'b0;
            cycles_q  <= '0;
        end else begin
            start_q <= ctrl_start_wr;
            if (done_e) begin
                done_q <= done;
            end
            if (running_e) begin
                running_q <= running;
            end
            if (start_q) begin
                cycles_q <= '0;
            end else if (running_q) begin
                cycles_q <= cycles_q + 1'b1;
            end
            // A set in the same cycle as a clear must win.
            if (err_set) begin
                err_q <= 1'b1;
            end else if (err_clr_wr) begin
                err_q <= 1'b0;
            end
        end
    end

    // The RAM output is shared, so each requester keeps its own copy of the
    // last returned word and only sees live RAM data in its response cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcu_mem_pend <= 1'b0;
            mcu_reg_pend <= 1'b0;
            reg_rdata_q  <= '0;
            mcu_hold_q   <= '0;
            acc_pend     <= 1'b0;
            acc_hold_q   <= '0;
        end else begin
            mcu_mem_pend <= mcu_mem_acc && !mcu_we;
            mcu_reg_pend <= mcu_reg_acc && !mcu_we;
            if (mcu_reg_acc && !mcu_we) begin
                reg_rdata_q <= reg_rd_val;
            end
            if (mcu_rvalid) begin
                mcu_hold_q <= mcu_rdata;
            end
            acc_pend <= acc_acc && !acc_we;
            if (acc_pend) begin
                acc_hold_q <= ram_rdata;
            end
        end
    end

    assign mcu_rvalid = mcu_mem_pend || mcu_reg_pend;
    assign mcu_rdata  = mcu_mem_pend ? ram_rdata :
                        mcu_reg_pend ? reg_rdata_q : mcu_hold_q;
    assign acc_rdata  = acc_pend ? ram_rdata : acc_hold_q;
    assign start      = start_q;

endmodule

// File: tb/tb_accel_mem_resp.sv
// Directed bench for accel_mem_resp: shared memory access, register space, start/CYCLES, reset.
module tb_accel_mem_resp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mcu_req, mcu_we;
    logic [10:0] mcu_addr;
    logic [31:0] mcu_wdata;
    logic        mcu_gnt;
    logic [31:0] mcu_rdata;
    logic        mcu_rvalid;
    logic        acc_req, acc_we;
    logic [9:0]  acc_addr;
    logic [31:0] acc_wdata;
    logic [31:0] acc_rdata;
    logic        ext_sel, done, done_e, running, running_e;
    logic        start;

    int checks = 0;
    int errors = 0;

    localparam logic [10:0] A_CTRL   = 11'h400;
    localparam logic [10:0] A_STATUS = 11'h401;
    localparam logic [10:0] A_CYCLES = 11'h402;
    localparam logic [10:0] A_RSVD   = 11'h403;

    accel_mem_resp dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mcu_req    (mcu_req),
        .mcu_we     (mcu_we),
        .mcu_addr   (mcu_addr),
        .mcu_wdata  (mcu_wdata),
        .mcu_gnt    (mcu_gnt),
        .mcu_rdata  (mcu_rdata),
        .mcu_rvalid (mcu_rvalid),
        .acc_req    (acc_req),
        .acc_we     (acc_we),
        .acc_addr   (acc_addr),
        .acc_wdata  (acc_wdata),
        .acc_rdata  (acc_rdata),
        .ext_sel    (ext_sel),
        .done       (done),
        .done_e     (done_e),
        .running    (running),
        .running_e  (running_e),
        .start      (start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic mcu_wr(input logic [10:0] addr, input logic [31:0] data);
        mcu_req   = 1'b1;
        mcu_we    = 1'b1;
        mcu_addr  = addr;
        mcu_wdata = data;
        #1;
        check("wr_gnt", {31'b0, mcu_gnt}, 32'd1);
        @(posedge clk);
        #1;
        mcu_req = 1'b0;
        mcu_we  = 1'b0;
    endtask

    task automatic mcu_rd(input string tag, input logic [10:0] addr, input logic [31:0] exp);
        mcu_req  = 1'b1;
        mcu_we   = 1'b0;
        mcu_addr = addr;
        #1;
        check({tag, "_gnt"}, {31'b0, mcu_gnt}, 32'd1);
        @(posedge clk);
        #1;
        mcu_req = 1'b0;
        check({tag, "_rvalid"}, {31'b0, mcu_rvalid}, 32'd1);
        check(tag, mcu_rdata, exp);
    endtask

    task automatic acc_op(input logic we, input logic [9:0] addr, input logic [31:0] data);
        acc_req   = 1'b1;
        acc_we    = we;
        acc_addr  = addr;
        acc_wdata = data;
        @(posedge clk);
        #1;
        acc_req = 1'b0;
        acc_we  = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        mcu_req = 0; mcu_we = 0; mcu_addr = '0; mcu_wdata = '0;
        acc_req = 0; acc_we = 0; acc_addr = '0; acc_wdata = '0;
        ext_sel = 0; done = 0; done_e = 0; running = 0; running_e = 0;
        #2;
        check("rst_start", {31'b0, start}, 32'd0);
        check("rst_rvalid", {31'b0, mcu_rvalid}, 32'd0);
        check("rst_mcu_rdata", mcu_rdata, 32'd0);
        check("rst_acc_rdata", acc_rdata, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mcu_rd("rst_status", A_STATUS, 32'd0);
        mcu_rd("rst_cycles", A_CYCLES, 32'd0);

        // MCU owns memory: write then read back.
        ext_sel = 1'b1;
        mcu_wr(11'd5, 32'hA5A5_0001);
        mcu_rd("mcu_rd5", 11'd5, 32'hA5A5_0001);
        @(posedge clk);
        #1;
        check("rvalid_one_cycle", {31'b0, mcu_rvalid}, 32'd0);
        check("mcu_rdata_hold", mcu_rdata, 32'hA5A5_0001);

        // Reserved and CTRL registers read 0.
        mcu_wr(A_RSVD, 32'hFFFF_FFFF);
        mcu_rd("rsvd_rd", A_RSVD, 32'd0);
        mcu_rd("ctrl_rd", A_CTRL, 32'd0);

        // Start pulse, then running status, then blocked second start.
        mcu_wr(A_CTRL, 32'd1);
        check("start_pulse", {31'b0, start}, 32'd1);
        running = 1'b1; running_e = 1'b1;
        @(posedge clk);
        #1;
        running_e = 1'b0;
        check("start_one_cycle", {31'b0, start}, 32'd0);
        mcu_rd("status_running", A_STATUS, 32'h2);
        mcu_wr(A_CTRL, 32'd1);
        check("start_blocked", {31'b0, start}, 32'd0);
        @(posedge clk);
        #1;
        check("start_blocked2", {31'b0, start}, 32'd0);
        running = 1'b0; running_e = 1'b1;
        @(posedge clk);
        #1;
        running_e = 1'b0;

        // Accelerator owns memory: MCU memory access stalls.
        ext_sel  = 1'b0;
        mcu_req  = 1'b1;
        mcu_we   = 1'b0;
        mcu_addr = 11'd5;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("mcu_stall_gnt", {31'b0, mcu_gnt}, 32'd0);
            @(posedge clk);
            #1;
            check("mcu_stall_rvalid", {31'b0, mcu_rvalid}, 32'd0);
        end
        ext_sel = 1'b1;
        mcu_rd("mcu_rd_after_stall", 11'd5, 32'hA5A5_0001);

        ext_sel = 1'b0;
        acc_op(1'b0, 10'd5, 32'd0);
        check("acc_rd5", acc_rdata, 32'hA5A5_0001);
        acc_op(1'b1, 10'd6, 32'h1234_5678);
        check("acc_wr_keeps_rdata", acc_rdata, 32'hA5A5_0001);
        acc_op(1'b0, 10'd6, 32'd0);
        check("acc_rd6", acc_rdata, 32'h1234_5678);
        acc_op(1'b0, 10'd5, 32'd0);
        check("acc_rd5b", acc_rdata, 32'hA5A5_0001);

        // Accelerator access while MCU owns memory: ignored, sets err.
        ext_sel = 1'b1;
        acc_op(1'b1, 10'd5, 32'hDEAD_BEEF);
        mcu_rd("status_err", A_STATUS, 32'h4);
        mcu_rd("mem5_unchanged", 11'd5, 32'hA5A5_0001);
        mcu_rd("mcu_rd6", 11'd6, 32'h1234_5678);
        check("acc_rdata_hold", acc_rdata, 32'hA5A5_0001);
        mcu_wr(A_STATUS, 32'h4);
        mcu_rd("status_err_clr", A_STATUS, 32'h0);
        acc_req = 1'b1;
        acc_we  = 1'b0;
        mcu_wr(A_STATUS, 32'h4);
        acc_req = 1'b0;
        mcu_rd("status_set_wins", A_STATUS, 32'h4);
        mcu_wr(A_STATUS, 32'h4);
        mcu_rd("status_clr2", A_STATUS, 32'h0);

        // 100 cycles of running_q, then done.
        mcu_wr(A_CTRL, 32'd1);
        check("start_pulse2", {31'b0, start}, 32'd1);
        running = 1'b1; running_e = 1'b1;
        @(posedge clk);
        #1;
        running_e = 1'b0;
        repeat (99) @(posedge clk);
        #1;
        running = 1'b0; running_e = 1'b1;
        done = 1'b1; done_e = 1'b1;
        @(posedge clk);
        #1;
        running_e = 1'b0; done_e = 1'b0;
        mcu_rd("cycles_100", A_CYCLES, 32'd100);
        mcu_rd("status_done", A_STATUS, 32'h1);

        // Reset right after a CTRL write aborts the start pulse.
        mcu_req   = 1'b1;
        mcu_we    = 1'b1;
        mcu_addr  = A_CTRL;
        mcu_wdata = 32'd1;
        @(posedge clk);
        rst_n   = 1'b0;
        mcu_req = 1'b0;
        mcu_we  = 1'b0;
        #1;
        check("rst_abort_start", {31'b0, start}, 32'd0);
        check("rst_abort_acc_rdata", acc_rdata, 32'd0);
        check("rst_abort_mcu_rdata", mcu_rdata, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("no_start_after_rst", {31'b0, start}, 32'd0);
        end
        mcu_rd("post_rst_status", A_STATUS, 32'd0);
        mcu_rd("post_rst_cycles", A_CYCLES, 32'd0);
        mcu_rd("post_rst_ctrl", A_CTRL, 32'd0);
        mcu_rd("mem_not_reset", 11'd5, 32'hA5A5_0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
